apb_mem_bridge: RTL

- APB3 completer that turns APB read/write transfers into single-word strobes on the synchronous memory port (en / wr / addr / wdata / rdata, registered read data) used by the team's memory model.
- Sits between the APB controller's requester and one memory instance.
- Owns address decode, range/alignment checking, read-latency wait states and PSLVERR generation.

---
 rtl/apb_mem_pkg.sv | 35 +++
 rtl/apb_mem_addr_chk.sv | 22 ++
 rtl/apb_mem_bridge.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/apb_mem_pkg.sv
// Shared types and address helpers for the APB-to-memory bridge.
package apb_mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RWAIT,
        RESP,
        ERR
    } state_e;

    localparam int MAX_PADDR_WIDTH = 64;
    localparam int CNT_WIDTH       = 3;

    // Byte-offset bits inside one data word.
    function automatic int calc_ofs(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // Set when a byte offset bit or any bit above the word-address field is non-zero.
    function automatic logic addr_err(input logic [MAX_PADDR_WIDTH-1:0] paddr,
                                      input int ofs,
                                      input int addr_width);
        logic err;
        err = 1'b0;
        for (int i = 0; i < MAX_PADDR_WIDTH; i++) begin
            if ((i < ofs || i >= ofs + addr_width) && paddr[i]) begin
                err = 1'b1;
            end
        end
        return err;
    endfunction

endpackage

// File: rtl/apb_mem_addr_chk.sv
// Combinational APB address decode: word address plus misalignment/range error flag.
module apb_mem_addr_chk
    import apb_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int PADDR_WIDTH = 32
) (
    input  logic [PADDR_WIDTH-1:0] paddr,
    output logic                   err,
    output logic [ADDR_WIDTH-1:0]  word_addr
);

    localparam int OFS = calc_ofs(DATA_WIDTH);

    logic [MAX_PADDR_WIDTH-1:0] paddr_ext;

    assign paddr_ext = MAX_PADDR_WIDTH'(paddr);
    assign err       = addr_err(paddr_ext, OFS, ADDR_WIDTH);
    assign word_addr = paddr[OFS+ADDR_WIDTH-1:OFS];

endmodule

// File: rtl/apb_mem_bridge.sv
// APB3 completer driving a single-word synchronous memory port with
// registered outputs, read-latency wait states and PSLVERR on bad addresses.
module apb_mem_bridge
    import apb_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int PADDR_WIDTH    = 32,
    parameter int MEM_RD_LATENCY = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_psel,
    input  logic                   i_penable,
    input  logic                   i_pwrite,
    input  logic [PADDR_WIDTH-1:0] i_paddr,
    input  logic [DATA_WIDTH-1:0]  i_pwdata,
    output logic [DATA_WIDTH-1:0]  o_prdata,
    output logic                   o_pready,
    output logic                   o_pslverr,
    output logic                   o_mem_en,
    output logic                   o_mem_wr,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    output logic [DATA_WIDTH-1:0]  o_mem_wdata,
    input  logic [DATA_WIDTH-1:0]  i_mem_rdata
);

    localparam logic [CNT_WIDTH-1:0] RD_LAT = CNT_WIDTH'(MEM_RD_LATENCY);

    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_dec;
    logic                   abort_q, abort_d;
    logic                   addr_err_w;
    logic [ADDR_WIDTH-1:0]  word_addr;

    logic [DATA_WIDTH-1:0]  prdata_d;
    logic                   pready_d;
    logic                   pslverr_d;
    logic                   mem_en_d;
    logic                   mem_wr_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_d;
    logic [DATA_WIDTH-1:0]  mem_wdata_d;

    apb_mem_addr_chk #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .PADDR_WIDTH(PADDR_WIDTH)
    ) u_addr_chk (
        .paddr    (i_paddr),
        .err      (addr_err_w),
        .word_addr(word_addr)
    );

    assign cnt_dec = cnt_q - 1'b1;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        abort_d     = abort_q;
        prdata_d    = o_prdata;
        pready_d    = 1'b0;
        pslverr_d   = 1'b0;
        mem_en_d    = 1'b0;
        mem_wr_d    = 1'b0;
        mem_addr_d  = o_mem_addr;
        mem_wdata_d = o_mem_wdata;

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (i_psel && !i_penable) begin
                    if (addr_err_w) begin
                        state_d   = ERR;
                        pready_d  = 1'b1;
                        pslverr_d = 1'b1;
                        if (!i_pwrite) begin
                            prdata_d = '0;
                        end
                    end else begin
                        state_d    = i_pwrite ? WR : RD;
                        mem_en_d   = 1'b1;
                        mem_wr_d   = i_pwrite;
                        mem_addr_d = word_addr;
                        if (i_pwrite) begin
                            mem_wdata_d = i_pwdata;
                        end
                    end
                end
            end
            WR: begin
                // A requester that dropped PSEL gets no PREADY; the write itself already went out.
                if (abort_q || !i_psel) begin
                    state_d = IDLE;
                end else begin
                    state_d  = RESP;
                    pready_d = 1'b1;
                end
            end
            RD: begin
                abort_d = abort_q | ~i_psel;
                cnt_d   = RD_LAT;
                state_d = RWAIT;
            end
            RWAIT: begin
                abort_d = abort_q | ~i_psel;
                cnt_d   = cnt_dec;
                if (cnt_dec == '0) begin
                    if (abort_d) begin
                        state_d = IDLE;
                    end else begin
                        state_d  = RESP;
                        pready_d = 1'b1;
                        prdata_d = i_mem_rdata;
                    end
                end
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            abort_q     <= 1'b0;
            o_prdata    <= '0;
            o_pready    <= 1'b0;
            o_pslverr   <= 1'b0;
            o_mem_en    <= 1'b0;
            o_mem_wr    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            abort_q     <= abort_d;
            o_prdata    <= prdata_d;
            o_pready    <= pready_d;
            o_pslverr   <= pslverr_d;
            o_mem_en    <= mem_en_d;
            o_mem_wr    <= mem_wr_d;
            o_mem_addr  <= mem_addr_d;
            o_mem_wdata <= mem_wdata_d;
        end
    end

endmodule
